// File: rtl/keypad_scan_encoder_pkg.sv
// Shared definitions for the keypad scanner: FSM encoding, key map,
// column drive table, default timing and a row-pattern decoder.
package keypad_scan_encoder_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_ACCEPT   = 2'd2,
        ST_HELD     = 2'd3
    } state_t;

    localparam int DEF_SCAN_DIV     = 1000;
    localparam int DEF_DEBOUNCE_CNT = 50000;

    // Digit for each key, indexed {row, col}.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Active-low one-cold column drive, indexed by column number.
    localparam logic [3:0] COL_ONE_COLD [4] = '{
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

    // Returns {hit, row_index}; hit only when exactly one row is low.
    function automatic logic [2:0] decode_row(input logic [3:0] rows);
        logic [2:0] res;
        case (rows)
            4'b1110: res = {1'b1, 2'd0};
            4'b1101: res = {1'b1, 2'd1};
            4'b1011: res = {1'b1, 2'd2};
            4'b0111: res = {1'b1, 2'd3};
            default: res = {1'b0, 2'd0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keypad_scan_encoder_if.sv
// Keypad matrix pins plus the downstream digit outputs and FSM debug state.
// The slave modport is the encoder; the master modport is whatever drives
// the rows and consumes the digits.
// key_valid is a one-cycle strobe with no back-pressure: key_code is valid
// in the strobe cycle and holds until the next strobe.
interface keypad_scan_encoder_if;
    import keypad_scan_encoder_pkg::*;

    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    state_t     dbg_state;

    modport slave (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held,
        output dbg_state
    );

    modport master (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  dbg_state
    );

endinterface

// File: rtl/keypad_scan_encoder_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows. Resets to all
// ones so that no key appears pressed while coming out of reset.
module row_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_i,
    output logic [3:0] rs_o
);

    logic [3:0] meta_q;
    logic [3:0] rs_q;

    // Two-stage capture of the raw row pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 4'hF;
            rs_q   <= 4'hF;
        end else begin
            meta_q <= row_i;
            rs_q   <= meta_q;
        end
    end

    assign rs_o = rs_q;

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad scanner: rotates the column drive, debounces a single-key
// press, emits one digit strobe per press, then waits for a debounced
// release before scanning again.
module keypad_scan_encoder
    import keypad_scan_encoder_pkg::*;
#(
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
    input  logic                  clk,
    input  logic                  reset,
    keypad_scan_encoder_if.slave  kp
);

    localparam int CNT_TOP = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CW      = $clog2(CNT_TOP);

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);

    logic [3:0]    rs;
    logic          row_hit;
    logic [1:0]    row_idx;

    state_t        state_q,    state_d;
    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic [CW-1:0] deb_cnt_q,  deb_cnt_d;
    logic [1:0]    col_idx_q,  col_idx_d;
    logic [3:0]    pat_q,      pat_d;
    logic [1:0]    r_q,        r_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q,  key_held_d;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    row_sync u_row_sync (
        .clk   (clk),
        .reset (reset),
        .row_i (kp.row),
        .rs_o  (rs)
    );

    assign {row_hit, row_idx} = decode_row(rs);

    // Next-state, counter and output decisions for the scan FSM.
    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        col_idx_d  = col_idx_q;
        pat_d      = pat_q;
        r_d        = r_q;
        key_code_d = key_code_q;

        case (state_q)
            ST_SCAN: begin
                // Rows are only trusted in the last clock of a dwell.
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (row_hit) begin
                        pat_d     = rs;
                        r_d       = row_idx;
                        deb_cnt_d = '0;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = sat_inc(scan_cnt_q);
                end
            end
            ST_DEBOUNCE: begin
                if (rs == pat_q) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        deb_cnt_d  = '0;
                        state_d    = ST_ACCEPT;
                        // Loaded on entry so the code is already valid
                        // during the strobe cycle.
                        key_code_d = KEY_MAP[{r_q, col_idx_q}];
                    end else begin
                        deb_cnt_d = sat_inc(deb_cnt_q);
                    end
                end else begin
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    col_idx_d  = col_idx_q + 2'd1;
                    state_d    = ST_SCAN;
                end
            end
            ST_ACCEPT: begin
                deb_cnt_d = '0;
                state_d   = ST_HELD;
            end
            ST_HELD: begin
                // Any low row, including a second key, restarts the release count.
                if (rs == 4'hF) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        deb_cnt_d  = '0;
                        scan_cnt_d = '0;
                        col_idx_d  = col_idx_q + 2'd1;
                        state_d    = ST_SCAN;
                    end else begin
                        deb_cnt_d = sat_inc(deb_cnt_q);
                    end
                end else begin
                    deb_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase

        key_valid_d = (state_d == ST_ACCEPT);
        key_held_d  = (state_d == ST_ACCEPT) || (state_d == ST_HELD);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SCAN;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            col_idx_q   <= 2'd0;
            pat_q       <= 4'hF;
            r_q         <= 2'd0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            col_idx_q   <= col_idx_d;
            pat_q       <= pat_d;
            r_q         <= r_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.col       = COL_ONE_COLD[col_idx_q];
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
    assign kp.dbg_state = state_q;

endmodule
